// File: rtl/triangle_bbox_scanner.sv
// Bounding-box raster walker feeding point_triangulator: latches a triangle, clamps its
// box to the screen, tests every pixel once and emits the inside ones as fragments.
module triangle_bbox_scanner #(
  parameter  int MAX_RESOLUTION_X = 1920,
  parameter  int MAX_RESOLUTION_Y = 1080,
  localparam int XW = $clog2(MAX_RESOLUTION_X),
  localparam int YW = $clog2(MAX_RESOLUTION_Y)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tri_valid,
  output logic          tri_ready,
  input  logic [XW-1:0] tri_p1_x,
  input  logic [XW-1:0] tri_p2_x,
  input  logic [XW-1:0] tri_p3_x,
  input  logic [YW-1:0] tri_p1_y,
  input  logic [YW-1:0] tri_p2_y,
  input  logic [YW-1:0] tri_p3_y,
  output logic [XW-1:0] test_point_x,
  output logic [YW-1:0] test_point_y,
  output logic [XW-1:0] test_p1_x,
  output logic [YW-1:0] test_p1_y,
  output logic [XW-1:0] test_p2_x,
  output logic [YW-1:0] test_p2_y,
  output logic [XW-1:0] test_p3_x,
  output logic [YW-1:0] test_p3_y,
  input  logic          test_is_inside,
  output logic          frag_valid,
  input  logic          frag_ready,
  output logic [XW-1:0] frag_x,
  output logic [YW-1:0] frag_y,
  output logic          done,
  output logic          busy
);

  localparam logic [XW-1:0] XLIM = XW'(MAX_RESOLUTION_X - 1);
  localparam logic [YW-1:0] YLIM = YW'(MAX_RESOLUTION_Y - 1);

  typedef enum logic [1:0] {IDLE, BBOX, SCAN, DONE} state_t;

  state_t        r_state, w_next;
  logic [XW-1:0] r_p1_x, r_p2_x, r_p3_x;
  logic [YW-1:0] r_p1_y, r_p2_y, r_p3_y;
  logic [XW-1:0] r_min_x, r_max_x, r_cur_x;
  logic [YW-1:0] r_min_y, r_max_y, r_cur_y;
  logic [XW-1:0] w_min_x, w_max_x, w_lo_x, w_hi_x;
  logic [YW-1:0] w_min_y, w_max_y, w_lo_y, w_hi_y;
  logic          w_accept, w_adv, w_last, w_row_end;

  assign w_accept  = tri_valid && (r_state == IDLE);
  assign w_adv     = (r_state == SCAN) && (!test_is_inside || frag_ready);
  assign w_row_end = (r_cur_x == r_max_x);
  assign w_last    = w_row_end && (r_cur_y == r_max_y);

  // Raw min/max of the latched vertices, then clamped onto the visible screen.
  always_comb begin
    w_lo_x = r_p1_x;
    w_hi_x = r_p1_x;
    if (r_p2_x < w_lo_x) w_lo_x = r_p2_x;
    if (r_p3_x < w_lo_x) w_lo_x = r_p3_x;
    if (r_p2_x > w_hi_x) w_hi_x = r_p2_x;
    if (r_p3_x > w_hi_x) w_hi_x = r_p3_x;
    w_lo_y = r_p1_y;
    w_hi_y = r_p1_y;
    if (r_p2_y < w_lo_y) w_lo_y = r_p2_y;
    if (r_p3_y < w_lo_y) w_lo_y = r_p3_y;
    if (r_p2_y > w_hi_y) w_hi_y = r_p2_y;
    if (r_p3_y > w_hi_y) w_hi_y = r_p3_y;
    w_min_x = (w_lo_x > XLIM) ? XLIM : w_lo_x;
    w_max_x = (w_hi_x > XLIM) ? XLIM : w_hi_x;
    w_min_y = (w_lo_y > YLIM) ? YLIM : w_lo_y;
    w_max_y = (w_hi_y > YLIM) ? YLIM : w_hi_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = BBOX;
      BBOX:    w_next = SCAN;
      SCAN:    if (w_adv && w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1_x  <= '0; r_p2_x <= '0; r_p3_x <= '0;
      r_p1_y  <= '0; r_p2_y <= '0; r_p3_y <= '0;
      r_min_x <= '0; r_max_x <= '0; r_cur_x <= '0;
      r_min_y <= '0; r_max_y <= '0; r_cur_y <= '0;
    end else begin
      if (w_accept) begin
        r_p1_x <= tri_p1_x; r_p2_x <= tri_p2_x; r_p3_x <= tri_p3_x;
        r_p1_y <= tri_p1_y; r_p2_y <= tri_p2_y; r_p3_y <= tri_p3_y;
      end
      if (r_state == BBOX) begin
        r_min_x <= w_min_x; r_max_x <= w_max_x; r_cur_x <= w_min_x;
        r_min_y <= w_min_y; r_max_y <= w_max_y; r_cur_y <= w_min_y;
      end
      // The final candidate leaves the counters parked on the max corner.
      if (w_adv && !w_last) begin
        if (!w_row_end) begin
          r_cur_x <= r_cur_x + XW'(1);
        end else begin
          r_cur_x <= r_min_x;
          r_cur_y <= r_cur_y + YW'(1);
        end
      end
    end
  end

  assign tri_ready    = (r_state == IDLE);
  assign busy         = (r_state != IDLE);
  assign done         = (r_state == DONE);
  assign frag_valid   = (r_state == SCAN) && test_is_inside;
  assign frag_x       = r_cur_x;
  assign frag_y       = r_cur_y;
  assign test_point_x = r_cur_x;
  assign test_point_y = r_cur_y;
  assign test_p1_x    = r_p1_x;
  assign test_p2_x    = r_p2_x;
  assign test_p3_x    = r_p3_x;
  assign test_p1_y    = r_p1_y;
  assign test_p2_y    = r_p2_y;
  assign test_p3_y    = r_p3_y;

endmodule
